// File: rtl/spi_slave_shifter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_slave_shifter_pkg                                        |
// | Description : Shared types and constants for the SPI mode-0 slave engine:  |
// |               FSM state encoding, default word width and the bit-counter   |
// |               width helper.                                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_slave_shifter_pkg;

  localparam int c_DATA_W_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Bit counter width: $clog2(DATA_W), never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_shifter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_slave_shifter_if                                         |
// | Description : Bundle of the SPI-side pulses/pins and the parallel RX/TX    |
// |               handshake of spi_slave_shifter.                              |
// |               slave  modport : the shifter (sclk/cs/mosi/tx in, rest out)  |
// |               master modport : the environment driving it                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface spi_slave_shifter_if
  import spi_slave_shifter_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEFAULT
);
  logic              sclk_rise;
  logic              sclk_fall;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;
  logic              frame_err;

  modport slave (
    input  sclk_rise, sclk_fall, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_err
  );

  modport master (
    output sclk_rise, sclk_fall, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_tx_holding_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_tx_holding_buf                                           |
// | Description : Single-entry ready/valid holding register for TX words.      |
// |   i_wr_valid/i_wr_data/o_wr_ready : producer handshake                     |
// |   i_take                          : shift register loads, entry consumed   |
// |   o_data/o_full                   : stored word and occupancy              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_tx_holding_buf #(
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_wr_valid,
  input  wire logic [DATA_W-1:0] i_wr_data,
  output logic                   o_wr_ready,
  input  wire logic              i_take,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_full
);
  logic              r_ready;
  logic [DATA_W-1:0] r_data;

  // A take while empty does not block a same-cycle write: the consumer gets
  // zeros and the offered word stays for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_data  <= '0;
    end else if (i_take && !r_ready) begin
      r_ready <= 1'b1;
    end else if (i_wr_valid && r_ready) begin
      r_ready <= 1'b0;
      r_data  <= i_wr_data;
    end
  end

  assign o_wr_ready = r_ready;
  assign o_full     = ~r_ready;
  assign o_data     = r_data;
endmodule
`default_nettype wire

// File: rtl/spi_slave_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_slave_shifter                                            |
// | Description : SPI mode-0 slave serial/parallel engine on the system clock. |
// |               MOSI sampled on sclk_rise, MISO updated on sclk_fall, MSB    |
// |               first. clk/rst plain ports; everything else on bus (slave).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_slave_shifter
  import spi_slave_shifter_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEFAULT
) (
  input  wire logic         clk,
  input  wire logic         rst,
  spi_slave_shifter_if.slave bus
);
  localparam int              c_CNT_W = cnt_width(DATA_W);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);

  state_t              r_state;
  logic                r_armed;
  logic [c_CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0]   r_rx_shift;
  logic [DATA_W-1:0]   r_tx_shift;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_miso;
  logic                r_miso_oe;
  logic                r_tx_underrun;
  logic                r_frame_err;

  logic                w_take;
  logic                w_buf_full;
  logic [DATA_W-1:0]   w_buf_data;
  logic [DATA_W-1:0]   w_load_word;
  logic [DATA_W-1:0]   w_rx_next;
  logic                w_start;
  logic                w_boundary;

  assign w_rx_next   = {r_rx_shift[DATA_W-2:0], bus.mosi};
  assign w_load_word = w_buf_full ? w_buf_data : '0;
  assign w_start     = (r_state == ST_IDLE) && r_armed && !bus.cs_n;
  // A fall coinciding with a rise is dropped, so it never consumes a word.
  assign w_boundary  = (r_state == ST_ACTIVE) && !bus.cs_n && !bus.sclk_rise &&
                       bus.sclk_fall && (r_bit_cnt == '0);
  assign w_take      = w_start || w_boundary;

  spi_tx_holding_buf #(.DATA_W(DATA_W)) u_tx_buf (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (bus.tx_valid),
    .i_wr_data  (bus.tx_data),
    .o_wr_ready (bus.tx_ready),
    .i_take     (w_take),
    .o_data     (w_buf_data),
    .o_full     (w_buf_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_armed       <= 1'b0;
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Arming on a seen-high CS_N ignores a frame already in progress.
          if (bus.cs_n) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state       <= ST_ACTIVE;
            r_armed       <= 1'b0;
            r_bit_cnt     <= '0;
            r_tx_shift    <= w_load_word;
            r_tx_underrun <= ~w_buf_full;
            r_miso        <= w_load_word[DATA_W-1];
            r_miso_oe     <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (bus.cs_n) begin
            r_state     <= ST_IDLE;
            r_frame_err <= (r_bit_cnt != '0);
            r_bit_cnt   <= '0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
          end else if (bus.sclk_rise) begin
            r_rx_shift <= w_rx_next;
            if (r_bit_cnt == c_LAST) begin
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (bus.sclk_fall) begin
            if (r_bit_cnt == '0) begin
              r_tx_shift    <= w_load_word;
              r_tx_underrun <= ~w_buf_full;
              r_miso        <= w_load_word[DATA_W-1];
            end else begin
              r_tx_shift <= r_tx_shift << 1;
              r_miso     <= r_tx_shift[DATA_W-2];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.miso        = r_miso;
  assign bus.miso_oe     = r_miso_oe;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_tx_underrun;
  assign bus.frame_err   = r_frame_err;
endmodule
`default_nettype wire
